// File: rtl/bcd_adder.sv
// Packed-BCD ripple adder with a registered output stage.
// Ports: clk, rst (sync, active-high), in_valid, a, b, cin -> sum, cout, out_valid, bcd_err.
module bcd_adder #(
    parameter int NUM_DIGITS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [4*NUM_DIGITS-1:0] a,
    input  logic [4*NUM_DIGITS-1:0] b,
    input  logic                    cin,
    output logic [4*NUM_DIGITS-1:0] sum,
    output logic                    cout,
    output logic                    out_valid,
    output logic                    bcd_err
);

    localparam int W = 4 * NUM_DIGITS;

    logic [W-1:0] core_sum;
    logic         core_cout;
    logic         core_err;

    logic [W-1:0] sum_d,       sum_q;
    logic         cout_d,      cout_q;
    logic         out_valid_d, out_valid_q;
    logic         bcd_err_d,   bcd_err_q;

    // Combinational ripple: each digit adds in binary, then a +6
    // correction (mod 16) folds sums above 9 back into decimal range.
    always_comb begin
        logic [4:0] dsum;
        logic       carry;
        dsum      = '0;
        carry     = cin;
        core_sum  = '0;
        core_err  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dsum = 5'(a[4*i +: 4]) + 5'(b[4*i +: 4]) + 5'(carry);
            if (dsum > 5'd9) begin
                core_sum[4*i +: 4] = dsum[3:0] + 4'd6;
                carry              = 1'b1;
            end else begin
                core_sum[4*i +: 4] = dsum[3:0];
                carry              = 1'b0;
            end
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                core_err = 1'b1;
            end
        end
        core_cout = carry;
    end

    // Results hold when no operation is accepted; only out_valid drops.
    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        bcd_err_d   = bcd_err_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            sum_d     = core_sum;
            cout_d    = core_cout;
            bcd_err_d = core_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            bcd_err_q   <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            bcd_err_q   <= bcd_err_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;
    assign bcd_err   = bcd_err_q;

endmodule

// File: tb/tb_bcd_adder.sv
// Bench for bcd_adder: directed steps plus random operands against a decimal model.
// Drives a 1-digit and a 4-digit instance from one sequence.
module tb_bcd_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  a1, b1, sum1;
    logic        cin1, cout1, ov1, err1;
    logic [15:0] a4, b4, sum4;
    logic        cin4, cout4, ov4, err4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_adder #(.NUM_DIGITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a1), .b(b1), .cin(cin1),
        .sum(sum1), .cout(cout1), .out_valid(ov1), .bcd_err(err1)
    );

    bcd_adder #(.NUM_DIGITS(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a4), .b(b4), .cin(cin4),
        .sum(sum4), .cout(cout4), .out_valid(ov4), .bcd_err(err4)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint unsigned bcd_to_int(input logic [63:0] v,
                                                   input int nd);
        longint unsigned r = 0;
        for (int i = nd - 1; i >= 0; i--) r = r * 10 + 64'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] int_to_bcd(input longint unsigned x,
                                               input int nd);
        logic [63:0] r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Digit-rule model, used where operands may hold non-decimal digits.
    task automatic rule_add(input logic [63:0] a, input logic [63:0] b,
                            input logic ci, input int nd,
                            output logic [63:0] s, output logic co,
                            output logic err);
        int c = int'(ci);
        int t;
        s = '0;
        err = 1'b0;
        for (int i = 0; i < nd; i++) begin
            t = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
            if (t > 9) begin
                s[4*i +: 4] = 4'((t + 6) % 16);
                c = 1;
            end else begin
                s[4*i +: 4] = 4'(t);
                c = 0;
            end
            if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) err = 1'b1;
        end
        co = (c != 0);
    endtask

    initial begin
        logic [63:0]     es;
        logic            ec, ee;
        longint unsigned tot;
        logic [15:0]     ra, rb;

        rst = 1'b1; in_valid = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0;
        step();
        chk("rst_sum1", 64'(sum1), 0);
        chk("rst_cout1", 64'(cout1), 0);
        chk("rst_ov1", 64'(ov1), 0);
        chk("rst_err1", 64'(err1), 0);
        chk("rst_sum4", 64'(sum4), 0);
        chk("rst_ov4", 64'(ov4), 0);
        rst = 1'b0;

        in_valid = 1'b1; a1 = 4'd1; b1 = 4'd9; cin1 = 1'b0;
        step();
        chk("t1a_sum", 64'(sum1), 0);
        chk("t1a_cout", 64'(cout1), 1);
        chk("t1a_ov", 64'(ov1), 1);
        chk("t1a_err", 64'(err1), 0);
        a1 = 4'd9; b1 = 4'd9; cin1 = 1'b1;
        step();
        chk("t1b_sum", 64'(sum1), 9);
        chk("t1b_cout", 64'(cout1), 1);

        a1 = 4'd1; b1 = 4'd5; cin1 = 1'b1;
        step();
        chk("t2a_sum", 64'(sum1), 7);
        chk("t2a_cout", 64'(cout1), 0);
        chk("t2a_ov", 64'(ov1), 1);
        a1 = 4'd7; b1 = 4'd9; cin1 = 1'b1;
        step();
        chk("t2b_sum", 64'(sum1), 7);
        chk("t2b_cout", 64'(cout1), 1);
        chk("t2b_ov", 64'(ov1), 1);
        a1 = 4'd7; b1 = 4'd7; cin1 = 1'b0;
        step();
        chk("t2c_sum", 64'(sum1), 4);
        chk("t2c_cout", 64'(cout1), 1);
        chk("t2c_ov", 64'(ov1), 1);

        a1 = 4'hC; b1 = 4'h1; cin1 = 1'b0;
        step();
        chk("t5_sum", 64'(sum1), 3);
        chk("t5_cout", 64'(cout1), 1);
        chk("t5_err", 64'(err1), 1);
        in_valid = 1'b0;
        step();
        chk("t5_hold_ov", 64'(ov1), 0);
        chk("t5_hold_err", 64'(err1), 1);
        chk("t5_hold_sum", 64'(sum1), 3);
        in_valid = 1'b1; a1 = 4'd2; b1 = 4'd3; cin1 = 1'b0;
        step();
        chk("t5_clr_err", 64'(err1), 0);
        chk("t5_clr_sum", 64'(sum1), 5);

        rst = 1'b1; a1 = 4'd9; b1 = 4'd9; cin1 = 1'b1;
        a4 = 16'h9999; b4 = 16'h9999; cin4 = 1'b1;
        step();
        chk("t3_sum", 64'(sum1), 0);
        chk("t3_cout", 64'(cout1), 0);
        chk("t3_ov", 64'(ov1), 0);
        chk("t3_err", 64'(err1), 0);
        chk("t3_sum4", 64'(sum4), 0);
        rst = 1'b0; a1 = 4'd8; b1 = 4'd4; cin1 = 1'b0;
        step();
        chk("t3_run_sum", 64'(sum1), 2);
        chk("t3_run_cout", 64'(cout1), 1);
        chk("max4_sum", 64'(sum4), 64'h9999);
        chk("max4_cout", 64'(cout4), 1);
        in_valid = 1'b0; a1 = 4'd0; b1 = 4'd0;
        step();
        chk("t3_idle_ov", 64'(ov1), 0);
        chk("t3_idle_sum", 64'(sum1), 2);
        chk("t3_idle_cout", 64'(cout1), 1);

        in_valid = 1'b1; a4 = 16'h9999; b4 = 16'h0000; cin4 = 1'b1;
        step();
        chk("t4a_sum", 64'(sum4), 0);
        chk("t4a_cout", 64'(cout4), 1);
        a4 = 16'h1234; b4 = 16'h5678; cin4 = 1'b0;
        step();
        chk("t4b_sum", 64'(sum4), 64'h6912);
        chk("t4b_cout", 64'(cout4), 0);
        chk("t4b_err", 64'(err4), 0);

        for (int x = 0; x < 10; x++) begin
            for (int y = 0; y < 10; y++) begin
                for (int c = 0; c < 2; c++) begin
                    a1 = 4'(x); b1 = 4'(y); cin1 = 1'(c);
                    step();
                    chk("t6_value", 64'(int'(cout1) * 10 + int'(sum1)),
                        64'(x + y + c));
                    chk("t6_err", 64'(err1), 0);
                end
            end
        end

        for (int n = 0; n < 200; n++) begin
            for (int d = 0; d < 4; d++) begin
                ra[4*d +: 4] = 4'($urandom_range(0, 9));
                rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            a4 = ra; b4 = rb; cin4 = 1'($urandom_range(0, 1));
            tot = bcd_to_int(64'(ra), 4) + bcd_to_int(64'(rb), 4)
                + 64'(cin4);
            step();
            chk("rnd_bcd_sum", 64'(sum4), int_to_bcd(tot % 10000, 4));
            chk("rnd_bcd_cout", 64'(cout4), 64'(tot >= 10000));
            chk("rnd_bcd_err", 64'(err4), 0);
        end

        for (int n = 0; n < 150; n++) begin
            a4 = 16'($urandom); b4 = 16'($urandom);
            cin4 = 1'($urandom_range(0, 1));
            a1 = 4'($urandom); b1 = 4'($urandom);
            cin1 = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 3) != 0);
            rule_add(64'(a4), 64'(b4), cin4, 4, es, ec, ee);
            step();
            if (in_valid) begin
                chk("rnd_raw_sum4", 64'(sum4), es);
                chk("rnd_raw_cout4", 64'(cout4), 64'(ec));
                chk("rnd_raw_err4", 64'(err4), 64'(ee));
                rule_add(64'(a1), 64'(b1), cin1, 1, es, ec, ee);
                chk("rnd_raw_sum1", 64'(sum1), es);
                chk("rnd_raw_cout1", 64'(cout1), 64'(ec));
                chk("rnd_raw_err1", 64'(err1), 64'(ee));
            end
            chk("rnd_ov", 64'(ov4), 64'(in_valid));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
